// File: rtl/sram_controller_pkg.sv
// ---------------------------------------------------------------------------
// sram_controller_pkg
//   Shared definitions for the MEM-stage SRAM controller slice.
//   - SramState      : FSM state encoding (IDLE/LOW/HIGH/DONE)
//   - SRAM_ADDR_BASE : CPU byte address that maps onto SRAM word 0
//   - HALF_W         : width of one SRAM access (the pad is 16 bits wide)
//   - DATA_W         : width of a CPU word as seen by the pipeline
// ---------------------------------------------------------------------------
package sram_controller_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        DONE = 2'd3
    } SramState;

    localparam int SRAM_ADDR_BASE = 1024;
    localparam int HALF_W         = 16;
    localparam int DATA_W         = 32;

endpackage

// File: rtl/sram_controller_if.sv
// ---------------------------------------------------------------------------
// sram_controller_if
//   Pipeline-side bus between the EXE/MEM pipeline register and the SRAM
//   controller.
//   Signals:
//     wr_en       store request (MEM_W_EN), held while ready is low
//     rd_en       load request (MEM_R_EN), held while ready is low
//     address     byte address (ALU_result)
//     write_data  store data (Val_Rm)
//     read_data   registered load result
//     ready       high when no access is pending or an access just finished
//   Modports:
//     master  the pipeline side that issues requests
//     slave   the controller that services them
// ---------------------------------------------------------------------------
interface sram_controller_if;
    import sram_controller_pkg::*;

    logic              wr_en;
    logic              rd_en;
    logic [DATA_W-1:0] address;
    logic [DATA_W-1:0] write_data;
    logic [DATA_W-1:0] read_data;
    logic              ready;

    modport master (
        output wr_en, rd_en, address, write_data,
        input  read_data, ready
    );

    modport slave (
        input  wr_en, rd_en, address, write_data,
        output read_data, ready
    );

endinterface

// File: rtl/sram_controller.sv
// ---------------------------------------------------------------------------
// sram_controller
//   Turns one 32-bit MEM-stage load or store into two 16-bit accesses on an
//   external asynchronous SRAM (low halfword first, then high halfword).
//   Each halfword phase lasts WAIT_CYCLES+1 clocks. While an access is in
//   flight, ready is low so the top level can freeze the pipeline.
//   Ports:
//     clk, rst     single clock, synchronous active-high reset
//     bus          pipeline-side request/response bus (slave modport)
//     sram_addr    halfword address to the SRAM
//     sram_dq_o    write data toward the pad
//     sram_dq_oe   pad drive enable (tristate is built at the top level)
//     sram_dq_i    data coming back from the pad
//     sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n
//                  active-low SRAM strobes
// ---------------------------------------------------------------------------
module sram_controller
    import sram_controller_pkg::*;
#(
    parameter int ADDR_BASE   = SRAM_ADDR_BASE,
    parameter int WAIT_CYCLES = 1,
    parameter int SRAM_AW     = 18
) (
    input  logic                clk,
    input  logic                rst,
    sram_controller_if.slave    bus,
    output logic [SRAM_AW-1:0]  sram_addr,
    output logic [HALF_W-1:0]   sram_dq_o,
    output logic                sram_dq_oe,
    input  logic [HALF_W-1:0]   sram_dq_i,
    output logic                sram_ce_n,
    output logic                sram_oe_n,
    output logic                sram_we_n,
    output logic                sram_ub_n,
    output logic                sram_lb_n
);

    // With WAIT_CYCLES=0 the counter is never needed, but a zero-width
    // vector is not legal, so keep at least one bit.
    localparam int CNT_W  = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam int WORD_W = SRAM_AW - 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES);

    SramState            state_q,   state_d;
    logic [CNT_W-1:0]    count_q,   count_d;
    logic                writeOp_q, writeOp_d;
    logic [WORD_W-1:0]   word_q,    word_d;
    logic [DATA_W-1:0]   wdata_q,   wdata_d;
    logic [DATA_W-1:0]   rdata_q,   rdata_d;

    logic [SRAM_AW-1:0]  addr_q,  addr_d;
    logic [HALF_W-1:0]   dqO_q,   dqO_d;
    logic                dqOe_q,  dqOe_d;
    logic                ceN_q,   ceN_d;
    logic                oeN_q,   oeN_d;
    logic                weN_q,   weN_d;

    logic                phaseActive;
    logic                phaseHigh;
    logic [DATA_W-1:0]   offset;
    logic [WORD_W-1:0]   reqWord;
    logic                unusedOffsetBits;

    // The SRAM word index is the byte offset from ADDR_BASE divided by four.
    // Byte lane bits and anything above the SRAM's reach are simply dropped,
    // so addresses below the base wrap to the top of the SRAM.
    assign offset           = bus.address - DATA_W'(ADDR_BASE);
    assign reqWord          = offset[SRAM_AW:2];
    assign unusedOffsetBits = ^{offset[DATA_W-1:SRAM_AW+1], offset[1:0]};

    // ready is deliberately combinational: a new request in IDLE must pull it
    // low in the same cycle so the pipeline freezes before the access starts.
    assign bus.ready     = (state_q == DONE) ||
                           ((state_q == IDLE) && !bus.rd_en && !bus.wr_en);
    assign bus.read_data = rdata_q;

    assign sram_addr  = addr_q;
    assign sram_dq_o  = dqO_q;
    assign sram_dq_oe = dqOe_q;
    assign sram_ce_n  = ceN_q;
    assign sram_oe_n  = oeN_q;
    assign sram_we_n  = weN_q;
    assign sram_ub_n  = ceN_q;
    assign sram_lb_n  = ceN_q;

    // Next-state logic. Requests are only looked at in IDLE; once an access
    // has been latched it always runs to completion. The pad is sampled on
    // the final cycle of each phase so the SRAM has had the full phase to
    // settle. The pin values are then decoded from the *next* state so the
    // strobes can be registered and reach the pads glitch-free.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        writeOp_d = writeOp_q;
        word_d    = word_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;

        case (state_q)
            IDLE: begin
                if (bus.rd_en || bus.wr_en) begin
                    writeOp_d = bus.wr_en;
                    word_d    = reqWord;
                    wdata_d   = bus.write_data;
                    count_d   = '0;
                    state_d   = LOW;
                end
            end
            LOW: begin
                if (count_q == CNT_LAST) begin
                    if (!writeOp_q) begin
                        rdata_d[HALF_W-1:0] = sram_dq_i;
                    end
                    count_d = '0;
                    state_d = HIGH;
                end else begin
                    count_d = count_q + CNT_W'(1);
                end
            end
            HIGH: begin
                if (count_q == CNT_LAST) begin
                    if (!writeOp_q) begin
                        rdata_d[DATA_W-1:HALF_W] = sram_dq_i;
                    end
                    count_d = '0;
                    state_d = DONE;
                end else begin
                    count_d = count_q + CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        phaseActive = (state_d == LOW) || (state_d == HIGH);
        phaseHigh   = (state_d == HIGH);

        ceN_d  = !phaseActive;
        weN_d  = !(phaseActive && writeOp_d);
        oeN_d  = !(phaseActive && !writeOp_d);
        dqOe_d = phaseActive && writeOp_d;
        addr_d = phaseActive ? {word_d, phaseHigh} : '0;
        dqO_d  = (phaseActive && writeOp_d)
                 ? (phaseHigh ? wdata_d[DATA_W-1:HALF_W] : wdata_d[HALF_W-1:0])
                 : '0;
    end

    // All controller state and every SRAM pin live in this one register
    // bank. Reset abandons any access in progress and parks the pins idle;
    // a request still held by the pipeline simply starts over afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            count_q   <= '0;
            writeOp_q <= 1'b0;
            word_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            addr_q    <= '0;
            dqO_q     <= '0;
            dqOe_q    <= 1'b0;
            ceN_q     <= 1'b1;
            oeN_q     <= 1'b1;
            weN_q     <= 1'b1;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            writeOp_q <= writeOp_d;
            word_q    <= word_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            addr_q    <= addr_d;
            dqO_q     <= dqO_d;
            dqOe_q    <= dqOe_d;
            ceN_q     <= ceN_d;
            oeN_q     <= oeN_d;
            weN_q     <= weN_d;
        end
    end

endmodule
